// File: rtl/alu_acc_sequencer.sv
// Purpose: command sequencer + accumulator/flag register around the 8-bit combinational ALU.
// Latency: command accepted at edge k, writeback and rsp_valid at edge k+1 (3 cycles/cmd, 2 with pipe).
// Backpressure: cmd_ready only when idle (or on a same-edge response handshake with ALU_SEQ_PIPE_EN); response held until rsp_ready.
// Optional build macro ALU_SEQ_PIPE_EN: lets a new command be accepted in RESP together with the response handshake.
module alu_acc_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_ac,
  input  logic       alu_s,
  input  logic       alu_z,
  input  logic       alu_p,
  output logic [7:0] acc,
  output logic [4:0] flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcode map: 0..11 go straight to the ALU, 12/13 are handled locally, 14/15 are illegal.
  localparam logic [3:0] OP_LAST_ALU = 4'd11;
  localparam logic [3:0] OP_FIRST_C  = 4'd8;
  localparam logic [3:0] OP_LOAD     = 4'd12;
  localparam logic [3:0] OP_CLRF     = 4'd13;

  // Bit positions inside flags = {s, z, ac, p, c}.
  localparam int F_C  = 0;
  localparam int F_P  = 1;
  localparam int F_AC = 2;
  localparam int F_Z  = 3;
  localparam int F_S  = 4;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] acc_q, acc_d;
  logic [4:0] flags_q, flags_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [3:0] alu_sel_q, alu_sel_d;
  logic       rsp_err_q, rsp_err_d;
  logic       accept;

  // Next-state decode and handshake outputs; cmd_ready depends only on state, rsp_ready and rst.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
`ifdef ALU_SEQ_PIPE_EN
        cmd_ready = rsp_ready;
`else
        cmd_ready = 1'b0;
`endif
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      cmd_ready = 1'b0;
    end
    accept = cmd_valid && cmd_ready;
    if (accept) begin
      state_d = EXEC;
    end
  end

  // Datapath: capture the command on accept, write back ALU/local results at the end of EXEC.
  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    flags_d   = flags_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    rsp_err_d = rsp_err_q;

    if (state_q == EXEC) begin
      if (op_q <= OP_LAST_ALU) begin
        acc_d        = alu_out;
        flags_d[F_Z] = alu_z;
        flags_d[F_P] = alu_p;
        // The ALU leaves c undefined below op 8 and ac/s undefined outside 8..9, so those hold.
        if (op_q >= OP_FIRST_C) begin
          flags_d[F_C] = alu_c;
        end
        if (op_q == 4'd8 || op_q == 4'd9) begin
          flags_d[F_AC] = alu_ac;
          flags_d[F_S]  = alu_s;
        end
        rsp_err_d = 1'b0;
      end else if (op_q == OP_LOAD) begin
        // alu_b still carries the captured command data.
        acc_d        = alu_b_q;
        flags_d[F_Z] = (alu_b_q == 8'h00);
        flags_d[F_P] = ^alu_b_q;
        rsp_err_d    = 1'b0;
      end else if (op_q == OP_CLRF) begin
        flags_d   = 5'b0;
        rsp_err_d = 1'b0;
      end else begin
        rsp_err_d = 1'b1;
      end
    end

    // In pipe mode the accept can coincide with RESP, where acc_q already holds the fresh result.
    if (accept) begin
      op_d      = cmd_op;
      alu_a_d   = acc_q;
      alu_b_d   = cmd_data;
      alu_sel_d = (cmd_op <= OP_LAST_ALU) ? cmd_op : 4'd0;
      rsp_err_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset that also drops any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 4'd0;
      acc_q     <= 8'd0;
      flags_q   <= 5'd0;
      alu_a_q   <= 8'd0;
      alu_b_q   <= 8'd0;
      alu_sel_q <= 4'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      flags_q   <= flags_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign acc     = acc_q;
  assign flags   = flags_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign rsp_err = rsp_err_q;

endmodule
